lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit between the EX/MEM pipeline register and the synchronous-read 64-word data memory.
- Accepts one memory request per handshake and converts the byte address to a word index, byte enables and lane-shifted store data.
- Sequences the one-cycle memory read latency, then extracts and sign/zero-extends load data.
- Returns a single-cycle response for writeback and stalls the pipeline through req_ready while busy.

Parameters:
XLEN, 32, data and address width.
DMEM_AW, 6, data memory word-index width (64 words).

Ports:
clk  in  1  single clock; all state updates on rising edge.
rst_n  in  1  reset, asynchronous, active-low.
req_valid  in  1  request present.
req_ready  out  1  unit can accept; high only in IDLE.
req_we  in  1  1 = store, 0 = load.
req_funct3  in  3  RV32I load/store funct3.
req_addr  in  XLEN  byte address.
req_wdata  in  XLEN  store data, right-aligned.
req_rd  in  5  load destination register.
mem_addr  out  DMEM_AW  word index = latched addr[DMEM_AW+1:2].
mem_re  out  1  read strobe.
mem_we  out  1  write strobe.
mem_be  out  4  byte-lane enables.
mem_wdata  out  XLEN  lane-shifted store data.
mem_rdata  in  XLEN  memory data, valid the cycle after mem_re.
resp_valid  out  1  one-cycle response pulse.
resp_rdata  out  XLEN  extended load data; 0 for stores and errors.
resp_rd  out  5  latched req_rd; 0 for stores.
resp_err  out  1  misaligned or illegal access.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all latched fields clear.
  - req_ready=1; every other output is 0, including resp_* and mem_*.
  - Any pending access is dropped; mem_we falls immediately, so no write occurs.
- Accept: req_valid && req_ready at edge T. All request fields are latched.
- mem_* and resp_* are decoded from state and latched registers only, never directly from req_* inputs.
- FSM: IDLE, ST_ISSUE, LD_ISSUE, LD_DATA, RESP.
  - IDLE: if the accepted request is in error, go to RESP with resp_err=1 and no memory strobe. Otherwise a store goes to ST_ISSUE and a load to LD_ISSUE.
  - ST_ISSUE (T+1): mem_we=1, mem_be and mem_wdata valid. Next RESP.
  - LD_ISSUE (T+1): mem_re=1. Next LD_DATA.
  - LD_DATA (T+2): sample mem_rdata, extract, and register into resp_rdata. Next RESP.
  - RESP: resp_valid=1 for exactly one cycle. Next IDLE.
- Response timing after accept: error at T+1, store at T+2, load at T+3.
- Throughput:
  - The next request can be accepted 3 cycles after a store accept and 4 cycles after a load accept.
  - Back-to-back requests need no idle bubble beyond this.
- Byte offset is off = addr[1:0].
- Store lanes:
  - SB: be = 1<<off; wdata = byte << 8*off.
  - SH: off 0 → be 0011, off 2 → be 1100; wdata = half << 8*off.
  - SW: be 1111; wdata unshifted.
- Load extraction:
  - LB/LBU select byte[off]; LH/LHU select half[off[1]].
  - Signed loads extend from the selected field's own MSB (bit 7 of the byte, bit 15 of the half).
  - LW passes the word through unchanged.
- Errors: halfword with off[0]=1; word with off!=0; load funct3 011/110/111; store funct3 other than 000/001/010.
- Without range checking, address bits above DMEM_AW+1 are ignored (modulo wrap).
- req_valid during a busy state is ignored; the requester holds its request until req_ready.

Optional Feature:
- Macro LSU_RANGE_CHECK_EN.
- Defined: any nonzero req_addr[XLEN-1:DMEM_AW+2] raises resp_err at T+1 and the memory is never touched.
- Undefined: upper address bits are ignored and accesses wrap.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - the state enum;
  - the byte-enable width constant.
- One sub-module: lsu_load_align. It is combinational: given mem_rdata, off and funct3, it produces the extended XLEN result. The FSM registers its output in LD_DATA.

Test Plan:
- SW addr 0x10, wdata 0xDEADBEEF → at T+1: mem_we=1, mem_addr=4, be=1111, wdata=0xDEADBEEF. At T+2: resp_valid=1, err=0.
- SB addr 0x13, wdata 0x000000A5 → mem_addr=4, be=1000, wdata=0xA5000000. SH addr 0x12, wdata 0x1234 → be=1100, wdata=0x12340000.
- Loads from memory word 4 = 0x12F45678, each with resp at T+3:
  - LB 0x12 → 0xFFFFFFF4; LBU 0x12 → 0x000000F4.
  - LH 0x12 → 0x000012F4; LHU 0x10 → 0x00005678.
  - LW 0x10 → 0x12F45678.
- LW addr 0x06, and separately LH addr 0x11 → resp_valid at T+1 with resp_err=1 and rdata=0. mem_re and mem_we are never asserted.
- SW accepted at T0 with a second request (LW) held → req_ready=0 at T+1 and T+2; the LW is accepted at edge T0+3. rst_n pulsed low during LD_DATA → outputs 0 immediately, and no resp_valid follows after release.
- Range check, SW addr 0x100:
  - With LSU_RANGE_CHECK_EN: resp_err=1 at T+1 and no mem_we.
  - Without it: mem_addr=0, mem_we=1 at T+1.

Source files
------------

// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit memory stage:
//   - RV32I load/store funct3 encodings
//   - FSM state encoding
//   - byte-enable width
//   - access legality helper (funct3 / alignment)
// -----------------------------------------------------------------------------
package lsu_pkg;

  localparam int LSU_BE_W = 4;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ST_ISSUE = 3'd1,
    LD_ISSUE = 3'd2,
    LD_DATA  = 3'd3,
    RESP     = 3'd4
  } lsu_state_e;

  // Returns 1 for an illegal funct3 or a misaligned halfword/word access.
  function automatic logic lsu_access_err(input logic       we,
                                          input logic [2:0] funct3,
                                          input logic [1:0] off);
    logic err;
    err = 1'b0;
    if (we) begin
      case (funct3)
        F3_B:    err = 1'b0;
        F3_H:    err = off[0];
        F3_W:    err = |off;
        default: err = 1'b1;
      endcase
    end else begin
      case (funct3)
        F3_B, F3_BU: err = 1'b0;
        F3_H, F3_HU: err = off[0];
        F3_W:        err = |off;
        default:     err = 1'b1;
      endcase
    end
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_stage_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Combinational load-data extraction: selects the byte/halfword addressed by
// the byte offset and sign- or zero-extends it to XLEN.
// Ports:
//   rdata_i  [XLEN-1:0]  raw memory word
//   off_i    [1:0]       byte offset within the word
//   funct3_i [2:0]       RV32I load funct3
//   result_o [XLEN-1:0]  extended load result (0 for an illegal funct3)
// -----------------------------------------------------------------------------
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      off_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata_i[{off_i, 3'b000} +: 8];
    // Halfwords are always 2-byte aligned here, so only off[1] matters.
    half_sel = rdata_i[{off_i[1], 4'b0000} +: 16];
    result_o = '0;
    case (funct3_i)
      F3_B:    result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_BU:   result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_H:    result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_HU:   result_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_W:    result_o = rdata_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// -----------------------------------------------------------------------------
// lsu_mem_stage
// Load/store unit between the EX/MEM pipeline register and a synchronous-read
// data memory. One request per handshake; byte address is converted into a
// word index, byte enables and lane-shifted store data. Loads wait out the
// one-cycle memory read latency and are extended by lsu_load_align.
//
// Optional feature: define LSU_RANGE_CHECK_EN to flag any nonzero address bit
// above the data memory range as an error (memory untouched). Without it the
// upper address bits are ignored and accesses wrap.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid / req_ready      request handshake (ready only in IDLE)
//   req_we, req_funct3         store/load select and RV32I funct3
//   req_addr, req_wdata        byte address, right-aligned store data
//   req_rd                     load destination register
//   mem_addr, mem_re, mem_we   word index and strobes to data memory
//   mem_be, mem_wdata          byte-lane enables and lane-shifted store data
//   mem_rdata                  memory read data, valid the cycle after mem_re
//   resp_valid                 one-cycle response pulse
//   resp_rdata, resp_rd        extended load data / destination (0 otherwise)
//   resp_err                   misaligned, illegal or out-of-range access
// -----------------------------------------------------------------------------
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int DMEM_AW = 6
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [2:0]          req_funct3,
  input  logic [XLEN-1:0]     req_addr,
  input  logic [XLEN-1:0]     req_wdata,
  input  logic [4:0]          req_rd,
  output logic [DMEM_AW-1:0]  mem_addr,
  output logic                mem_re,
  output logic                mem_we,
  output logic [LSU_BE_W-1:0] mem_be,
  output logic [XLEN-1:0]     mem_wdata,
  input  logic [XLEN-1:0]     mem_rdata,
  output logic                resp_valid,
  output logic [XLEN-1:0]     resp_rdata,
  output logic [4:0]          resp_rd,
  output logic                resp_err
);

  lsu_state_e state_q, state_d;

  logic               we_q;
  logic [2:0]         funct3_q;
  logic [1:0]         off_q;
  logic [DMEM_AW-1:0] widx_q;
  logic [XLEN-1:0]    wdata_q;
  logic [4:0]         rd_q;
  logic               err_q;
  logic [XLEN-1:0]    rdata_q;

  logic               accept;
  logic               range_err;
  logic               req_err;
  logic [XLEN-1:0]    load_ext;
  logic [LSU_BE_W-1:0] st_be;
  logic [XLEN-1:0]    st_wdata;

  assign accept = req_valid && (state_q == IDLE);

`ifdef LSU_RANGE_CHECK_EN
  assign range_err = |req_addr[XLEN-1:DMEM_AW+2];
`else
  // Upper address bits are deliberately ignored; accesses wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[XLEN-1:DMEM_AW+2];
  assign range_err = 1'b0;
`endif

  assign req_err = lsu_access_err(req_we, req_funct3, req_addr[1:0]) | range_err;

  // ---------------------------------------------------------------------------
  // State and latched request fields
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      off_q    <= 2'b00;
      widx_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= 5'd0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= req_we;
        funct3_q <= req_funct3;
        off_q    <= req_addr[1:0];
        widx_q   <= req_addr[DMEM_AW+1:2];
        wdata_q  <= req_wdata;
        rd_q     <= req_rd;
        err_q    <= req_err;
        // Cleared on accept so stores and errors respond with zero data.
        rdata_q  <= '0;
      end else if (state_q == LD_DATA) begin
        rdata_q <= load_ext;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (req_err)     state_d = RESP;
          else if (req_we) state_d = ST_ISSUE;
          else             state_d = LD_ISSUE;
        end
      end
      ST_ISSUE: state_d = RESP;
      LD_ISSUE: state_d = LD_DATA;
      LD_DATA:  state_d = RESP;
      RESP:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Store lane placement from latched fields
  // ---------------------------------------------------------------------------
  always_comb begin
    st_be    = '0;
    st_wdata = '0;
    case (funct3_q)
      F3_B: begin
        st_be    = LSU_BE_W'(1) << off_q;
        st_wdata = XLEN'(wdata_q[7:0]) << {off_q, 3'b000};
      end
      F3_H: begin
        st_be    = off_q[1] ? 4'b1100 : 4'b0011;
        st_wdata = XLEN'(wdata_q[15:0]) << {off_q[1], 4'b0000};
      end
      F3_W: begin
        st_be    = 4'b1111;
        st_wdata = wdata_q;
      end
      default: begin
        st_be    = '0;
        st_wdata = '0;
      end
    endcase
  end

  lsu_load_align #(
    .XLEN(XLEN)
  ) u_load_align (
    .rdata_i  (mem_rdata),
    .off_i    (off_q),
    .funct3_i (funct3_q),
    .result_o (load_ext)
  );

  // ---------------------------------------------------------------------------
  // Outputs: decoded from state and latched registers only
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready  = (state_q == IDLE);
    mem_we     = (state_q == ST_ISSUE);
    mem_re     = (state_q == LD_ISSUE);
    mem_addr   = (mem_we || mem_re) ? widx_q : '0;
    mem_be     = mem_we ? st_be : '0;
    mem_wdata  = mem_we ? st_wdata : '0;
    resp_valid = (state_q == RESP);
    resp_err   = resp_valid && err_q;
    resp_rdata = resp_valid ? rdata_q : '0;
    resp_rd    = (resp_valid && !we_q && !err_q) ? rd_q : 5'd0;
  end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  localparam int XLEN    = 32;
  localparam int DMEM_AW = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               req_valid = 1'b0;
  logic               req_ready;
  logic               req_we = 1'b0;
  logic [2:0]         req_funct3 = 3'b000;
  logic [XLEN-1:0]    req_addr = '0;
  logic [XLEN-1:0]    req_wdata = '0;
  logic [4:0]         req_rd = 5'd0;
  logic [DMEM_AW-1:0] mem_addr;
  logic               mem_re;
  logic               mem_we;
  logic [3:0]         mem_be;
  logic [XLEN-1:0]    mem_wdata;
  logic [XLEN-1:0]    mem_rdata = '0;
  logic               resp_valid;
  logic [XLEN-1:0]    resp_rdata;
  logic [4:0]         resp_rd;
  logic               resp_err;

  lsu_mem_stage #(.XLEN(XLEN), .DMEM_AW(DMEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rd(req_rd),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_rd(resp_rd),
    .resp_err(resp_err)
  );

  always #5 clk = ~clk;

  // Synchronous-read data memory seen by the DUT.
  logic [31:0] tb_mem [64];
  always @(posedge clk) begin
    if (mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) tb_mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
    if (mem_re) mem_rdata <= tb_mem[mem_addr];
  end

  // Reference model: flat byte-addressed image of the 256-byte memory.
  logic [7:0] ref_mem [256];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  function automatic bit model_err(input bit we, input logic [2:0] f3, input logic [31:0] addr);
    int nb;
    bit legal;
    nb = 1 << f3[1:0];
    legal = we ? (f3 <= 3'd2) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    if (!legal) return 1'b1;
    if ((addr % nb) != 0) return 1'b1;
`ifdef LSU_RANGE_CHECK_EN
    if (addr >= 32'd256) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic wait_ready();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("ready_wait", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic do_txn(input bit we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [4:0] rd,
                        output logic [31:0] o_rdata, output logic o_err);
    bit          err;
    int          nb, off, base, lat;
    logic [63:0] mask, lv;
    logic [31:0] exp_be, exp_wd, exp_rdata;
    logic [63:0] wd64;

    err  = model_err(we, f3, addr);
    nb   = 1 << f3[1:0];
    off  = addr % 4;
    base = (addr % 256) - off;
    lat  = err ? 1 : (we ? 2 : 3);
    mask = (64'd1 << (8*nb)) - 64'd1;
    exp_be = 32'(((1 << nb) - 1) << off);
    wd64   = (64'(wdata) & mask) << (8*off);
    exp_wd = wd64[31:0];
    lv = 64'd0;
    if (!err && !we) begin
      for (int i = 0; i < nb; i++) lv = lv | (64'(ref_mem[base+off+i]) << (8*i));
      if (!f3[2] && nb < 4 && lv[8*nb-1]) lv = lv - (64'd1 << (8*nb));
    end
    exp_rdata = lv[31:0];
    o_rdata = '0;
    o_err = 1'b0;

    wait_ready();
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
    req_wdata = wdata; req_rd = rd;
    @(posedge clk);
    #1;
    // Scramble the request inputs: the DUT must work from its latched copy.
    req_valid = 1'b0; req_we = 1'($urandom); req_funct3 = 3'($urandom);
    req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);

    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("mem_we", {31'd0, mem_we}, {31'd0, (!err && we)});
        check("mem_re", {31'd0, mem_re}, {31'd0, (!err && !we)});
        if (!err) check("mem_addr", 32'(mem_addr), 32'(base / 4));
        if (!err && we) begin
          check("mem_be", 32'(mem_be), exp_be);
          check("mem_wdata", mem_wdata, exp_wd);
        end
      end else begin
        check("mem_we_late", {31'd0, mem_we}, 32'd0);
        check("mem_re_late", {31'd0, mem_re}, 32'd0);
      end
      check("resp_valid", {31'd0, resp_valid}, {31'd0, (k == lat)});
      check("req_ready", {31'd0, req_ready}, {31'd0, (k > lat)});
      if (k == lat) begin
        check("resp_err", {31'd0, resp_err}, {31'd0, err});
        check("resp_rdata", resp_rdata, err ? 32'd0 : exp_rdata);
        if (!err) check("resp_rd", 32'(resp_rd), we ? 32'd0 : 32'(rd));
        o_rdata = resp_rdata;
        o_err   = resp_err;
      end
    end

    if (we && !err)
      for (int i = 0; i < nb; i++) ref_mem[base+off+i] = wdata[8*i +: 8];

    $display("txn %s f3=%0d addr=0x%08h wdata=0x%08h -> err=%0b rdata=0x%08h",
             we ? "ST" : "LD", f3, addr, wdata, o_err, o_rdata);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    check({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_mem_re"}, {31'd0, mem_re}, 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_resp_rdata"}, resp_rdata, 32'd0);
    check({tag, "_resp_rd"}, 32'(resp_rd), 32'd0);
    check({tag, "_resp_err"}, {31'd0, resp_err}, 32'd0);
  endtask

  logic [31:0] rdat;
  logic        rerr;
  logic [31:0] v;

  initial begin
    for (int w = 0; w < 64; w++) begin
      v = $urandom;
      tb_mem[w] = v;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = v[8*b +: 8];
    end

    #2;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed stores
    do_txn(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, rdat, rerr);
    check("sw_err", {31'd0, rerr}, 32'd0);
    do_txn(1'b1, 3'b000, 32'h13, 32'h000000A5, 5'd1, rdat, rerr);
    do_txn(1'b1, 3'b001, 32'h12, 32'h00001234, 5'd1, rdat, rerr);
    do_txn(1'b1, 3'b010, 32'h10, 32'h12F45678, 5'd1, rdat, rerr);

    // Directed loads from word 4 = 0x12F45678
    do_txn(1'b0, 3'b000, 32'h12, 32'h0, 5'd3, rdat, rerr);
    check("lb_0x12", rdat, 32'hFFFFFFF4);
    do_txn(1'b0, 3'b100, 32'h12, 32'h0, 5'd4, rdat, rerr);
    check("lbu_0x12", rdat, 32'h000000F4);
    do_txn(1'b0, 3'b001, 32'h12, 32'h0, 5'd5, rdat, rerr);
    check("lh_0x12", rdat, 32'h000012F4);
    do_txn(1'b0, 3'b101, 32'h10, 32'h0, 5'd6, rdat, rerr);
    check("lhu_0x10", rdat, 32'h00005678);
    do_txn(1'b0, 3'b010, 32'h10, 32'h0, 5'd7, rdat, rerr);
    check("lw_0x10", rdat, 32'h12F45678);

    // Misaligned accesses
    do_txn(1'b0, 3'b010, 32'h06, 32'h0, 5'd8, rdat, rerr);
    check("lw_mis_err", {31'd0, rerr}, 32'd1);
    check("lw_mis_rdata", rdat, 32'd0);
    do_txn(1'b0, 3'b001, 32'h11, 32'h0, 5'd9, rdat, rerr);
    check("lh_mis_err", {31'd0, rerr}, 32'd1);

    // Back-to-back: SW accepted, LW held until ready returns
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h20; req_wdata = 32'hA1B2C3D4; req_rd = 5'd0;
    @(posedge clk);
    #1;
    req_we = 1'b0; req_addr = 32'h20; req_rd = 5'd11;
    @(negedge clk);
    check("b2b_ready_t1", {31'd0, req_ready}, 32'd0);
    check("b2b_mem_we", {31'd0, mem_we}, 32'd1);
    @(negedge clk);
    check("b2b_ready_t2", {31'd0, req_ready}, 32'd0);
    check("b2b_st_resp", {31'd0, resp_valid}, 32'd1);
    @(negedge clk);
    check("b2b_ready_t3", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("b2b_ld_mem_re", {31'd0, mem_re}, 32'd1);
    check("b2b_ld_addr", 32'(mem_addr), 32'd8);
    @(negedge clk);
    @(negedge clk);
    check("b2b_ld_resp", {31'd0, resp_valid}, 32'd1);
    check("b2b_ld_rdata", resp_rdata, 32'hA1B2C3D4);
    check("b2b_ld_rd", 32'(resp_rd), 32'd11);
    $display("txn B2B SW/LW addr=0x00000020 -> rdata=0x%08h", resp_rdata);
    ref_mem[32] = 8'hD4; ref_mem[33] = 8'hC3; ref_mem[34] = 8'hB2; ref_mem[35] = 8'hA1;

    // Reset during LD_DATA
    wait_ready();
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10; req_rd = 5'd12;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_lddata");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    $display("txn RESET during LD_DATA");

    // Reset during ST_ISSUE: the write must be dropped
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h30; req_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_st_mem_we_before", {31'd0, mem_we}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_st_mem_we_after", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("txn RESET during ST_ISSUE");
    do_txn(1'b0, 3'b010, 32'h30, 32'h0, 5'd13, rdat, rerr);

    // Address beyond the memory range
    do_txn(1'b1, 3'b010, 32'h100, 32'h55AA55AA, 5'd0, rdat, rerr);
`ifdef LSU_RANGE_CHECK_EN
    check("range_err", {31'd0, rerr}, 32'd1);
`else
    check("range_wrap_err", {31'd0, rerr}, 32'd0);
    do_txn(1'b0, 3'b010, 32'h0, 32'h0, 5'd14, rdat, rerr);
    check("range_wrap_data", rdat, 32'h55AA55AA);
`endif

    // Randomized traffic against the reference model
    for (int t = 0; t < 150; t++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
      do_txn(1'($urandom), 3'($urandom_range(0, 7)), a, $urandom, 5'($urandom), rdat, rerr);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
